// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: FSM states and the
// external SRAM data width.
package mem_stage_sram_ctrl_pkg;

    localparam int SRAM_DW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mem_stage_sram_ctrl_if.sv
// Bus bundle between the EXE/MEM pipeline register, the controller and the SRAM pins.
// The controller takes the slave view; the pipeline/SRAM environment takes the master view.
interface mem_stage_sram_ctrl_if #(
    parameter int ADDR_W = 18
);
    import mem_stage_sram_ctrl_pkg::*;

    logic                MEM_R_EN;
    logic                MEM_W_EN;
    logic [31:0]         addr;
    logic [31:0]         wdata;
    logic [31:0]         rdata;
    logic                ready;
    logic                freeze;
    logic [ADDR_W-1:0]   sram_addr;
    logic [SRAM_DW-1:0]  sram_dq_o;
    logic                sram_dq_oe;
    logic [SRAM_DW-1:0]  sram_dq_i;
    logic                sram_we_n;

    modport master (
        output MEM_R_EN, MEM_W_EN, addr, wdata, sram_dq_i,
        input  rdata, ready, freeze, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n
    );

    modport slave (
        input  MEM_R_EN, MEM_W_EN, addr, wdata, sram_dq_i,
        output rdata, ready, freeze, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n
    );

endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// Sequences a 32-bit MEM-stage load/store as two half-word phases on a 16-bit
// asynchronous SRAM, stalling the pipeline via freeze until the word completes.
module mem_stage_sram_ctrl
    import mem_stage_sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 4,
    parameter int BASE_ADDR   = 1024,
    parameter int ADDR_W      = 18
) (
    input logic                  clk,
    input logic                  rst,
    mem_stage_sram_ctrl_if.slave bus
);

    localparam int               CNT_W       = $clog2(WAIT_CYCLES + 1);
    localparam int               IDX_W       = ADDR_W - 1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [31:0]      BASE        = 32'(BASE_ADDR);
    localparam bit               MULTI_CYCLE = (WAIT_CYCLES > 1);

    state_t             state, state_next;
    logic [CNT_W-1:0]   count, count_next;
    logic [ADDR_W-1:0]  addr_q, addr_next;
    logic [SRAM_DW-1:0] dq_q, dq_next;
    logic               oe_q, oe_next;
    logic               we_n_q, we_n_next;
    logic [31:0]        rdata_q;
    logic               ready_q;
    logic               req, is_write, cnt_last;
    logic               in_phase_next, half_next;
    logic [IDX_W-1:0]   word_idx;

    assign req      = bus.MEM_R_EN | bus.MEM_W_EN;
    assign is_write = bus.MEM_W_EN;
    assign cnt_last = (count == CNT_LAST);
    // Offset wraps in 32 bits; anything above the SRAM address range is dropped.
    assign word_idx = IDX_W'((bus.addr - BASE) >> 2);

    assign bus.freeze     = req && (state != DONE);
    assign bus.ready      = ready_q;
    assign bus.rdata      = rdata_q;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_dq_o  = dq_q;
    assign bus.sram_dq_oe = oe_q;
    assign bus.sram_we_n  = we_n_q;

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE: begin
                if (req) begin
                    state_next = LO;
                    count_next = '0;
                end
            end
            LO: begin
                if (cnt_last) begin
                    state_next = HI;
                    count_next = '0;
                end else begin
                    count_next = count + CNT_W'(1);
                end
            end
            HI: begin
                if (cnt_last) state_next = DONE;
                else          count_next = count + CNT_W'(1);
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Pins are registered from the next state so they line up with the phase.
        in_phase_next = (state_next == LO) || (state_next == HI);
        half_next     = (state_next == HI);
        addr_next     = addr_q;
        dq_next       = dq_q;
        if (in_phase_next) begin
            addr_next = {word_idx, half_next};
            dq_next   = half_next ? bus.wdata[31:16] : bus.wdata[15:0];
        end
        oe_next   = in_phase_next && is_write;
        // The strobe rises one cycle before the phase ends so data is held past we_n.
        we_n_next = !(in_phase_next && is_write &&
                      !(MULTI_CYCLE && (count_next == CNT_LAST)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            addr_q  <= '0;
            dq_q    <= '0;
            oe_q    <= 1'b0;
            we_n_q  <= 1'b1;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            addr_q  <= addr_next;
            dq_q    <= dq_next;
            oe_q    <= oe_next;
            we_n_q  <= we_n_next;
            ready_q <= (state_next == DONE);
            if (state == LO && cnt_last && !is_write) rdata_q[15:0]  <= bus.sram_dq_i;
            if (state == HI && cnt_last && !is_write) rdata_q[31:16] <= bus.sram_dq_i;
        end
    end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Self-checking bench: two controllers (WAIT_CYCLES 4 and 1) against a timeline
// model of the word access, plus directed literal checks and random traffic.
module tb_mem_stage_sram_ctrl;

    localparam int AW = 18;
    localparam int WC [2] = '{4, 1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_stage_sram_ctrl_if #(.ADDR_W(AW)) bus4 ();
    mem_stage_sram_ctrl_if #(.ADDR_W(AW)) bus1 ();

    mem_stage_sram_ctrl #(.WAIT_CYCLES(4), .BASE_ADDR(1024), .ADDR_W(AW)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4)
    );
    mem_stage_sram_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(1024), .ADDR_W(AW)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    // Stimulus arrays, index 0 -> WAIT 4 instance, index 1 -> WAIT 1 instance
    logic        r_en [2];
    logic        w_en [2];
    logic [31:0] addr_in [2];
    logic [31:0] wdata_in [2];
    logic [15:0] dq_in [2];

    assign bus4.MEM_R_EN = r_en[0];  assign bus1.MEM_R_EN = r_en[1];
    assign bus4.MEM_W_EN = w_en[0];  assign bus1.MEM_W_EN = w_en[1];
    assign bus4.addr = addr_in[0];   assign bus1.addr = addr_in[1];
    assign bus4.wdata = wdata_in[0]; assign bus1.wdata = wdata_in[1];
    assign bus4.sram_dq_i = dq_in[0]; assign bus1.sram_dq_i = dq_in[1];

    logic [31:0] rdata_o [2];
    logic        ready_o [2];
    logic        freeze_o [2];
    logic [AW-1:0] saddr_o [2];
    logic [15:0] dq_o [2];
    logic        oe_o [2];
    logic        we_n_o [2];

    assign rdata_o[0] = bus4.rdata;      assign rdata_o[1] = bus1.rdata;
    assign ready_o[0] = bus4.ready;      assign ready_o[1] = bus1.ready;
    assign freeze_o[0] = bus4.freeze;    assign freeze_o[1] = bus1.freeze;
    assign saddr_o[0] = bus4.sram_addr;  assign saddr_o[1] = bus1.sram_addr;
    assign dq_o[0] = bus4.sram_dq_o;     assign dq_o[1] = bus1.sram_dq_o;
    assign oe_o[0] = bus4.sram_dq_oe;    assign oe_o[1] = bus1.sram_dq_oe;
    assign we_n_o[0] = bus4.sram_we_n;   assign we_n_o[1] = bus1.sram_we_n;

    int tests = 0;
    int fails = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Asynchronous SRAM model; unwritten locations return an address-derived pattern
    logic [15:0] mem4 [int];
    logic [15:0] mem1 [int];

    function automatic logic [15:0] sram_read(input int d, input int a);
        if (d == 0) return mem4.exists(a) ? mem4[a] : (16'(a) ^ 16'hA5A5);
        return mem1.exists(a) ? mem1[a] : (16'(a) ^ 16'hA5A5);
    endfunction

    always @(negedge clk) begin
        if (!bus4.sram_we_n) mem4[int'(bus4.sram_addr)] = bus4.sram_dq_o;
        if (!bus1.sram_we_n) mem1[int'(bus1.sram_addr)] = bus1.sram_dq_o;
        dq_in[0] = sram_read(0, int'(bus4.sram_addr));
        dq_in[1] = sram_read(1, int'(bus1.sram_addr));
    end

    // Reference model: position k within the access timeline.
    // k=0 idle/request cycle, 1..W low half, W+1..2W high half, 2W+1 done.
    bit          busy [2];
    int          k [2];
    logic [AW-1:0] last_addr [2];
    logic [15:0] last_dq [2];
    logic [31:0] exp_rdata [2];

    function automatic logic [AW-1:0] map_addr(input logic [31:0] a, input bit half);
        logic [31:0] off;
        off = a - 32'd1024;
        return AW'((((off >> 2) & 32'h1FFFF) << 1) | 32'(half));
    endfunction

    function automatic bit in_phase(input int d);
        return busy[d] && k[d] >= 1 && k[d] <= 2 * WC[d];
    endfunction

    function automatic bit half_of(input int d);
        return k[d] > WC[d];
    endfunction

    function automatic int j_of(input int d);
        return half_of(d) ? k[d] - 1 - WC[d] : k[d] - 1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                busy[d] = 1'b0; k[d] = 0; last_addr[d] = '0;
                last_dq[d] = '0; exp_rdata[d] = '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                logic [15:0] v;
                if (in_phase(d) && !w_en[d] && j_of(d) == WC[d] - 1) begin
                    v = sram_read(d, int'(map_addr(addr_in[d], half_of(d))));
                    if (half_of(d)) exp_rdata[d][31:16] = v;
                    else            exp_rdata[d][15:0]  = v;
                end
                if (!busy[d]) begin
                    if (r_en[d] || w_en[d]) begin busy[d] = 1'b1; k[d] = 1; end
                end else if (k[d] == 2 * WC[d] + 1) begin
                    busy[d] = 1'b0; k[d] = 0;
                end else begin
                    k[d] = k[d] + 1;
                end
                if (in_phase(d)) begin
                    last_addr[d] = map_addr(addr_in[d], half_of(d));
                    last_dq[d]   = half_of(d) ? wdata_in[d][31:16] : wdata_in[d][15:0];
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            bit ph, dn;
            string p;
            p  = $sformatf("w%0d", WC[d]);
            ph = in_phase(d);
            dn = busy[d] && k[d] == 2 * WC[d] + 1;
            checkOutput({p, " freeze"}, 32'(freeze_o[d]), 32'((r_en[d] || w_en[d]) && !dn));
            checkOutput({p, " ready"}, 32'(ready_o[d]), 32'(dn));
            checkOutput({p, " oe"}, 32'(oe_o[d]), 32'(ph && w_en[d]));
            checkOutput({p, " we_n"}, 32'(we_n_o[d]),
                        32'(!(ph && w_en[d] && !(WC[d] > 1 && j_of(d) == WC[d] - 1))));
            checkOutput({p, " sram_addr"}, 32'(saddr_o[d]), 32'(last_addr[d]));
            if (ph && w_en[d]) checkOutput({p, " dq_o"}, 32'(dq_o[d]), 32'(last_dq[d]));
            checkOutput({p, " rdata"}, rdata_o[d], exp_rdata[d]);
        end
    end

    task automatic applyStimulus(input int d, input bit r, input bit w,
                                 input logic [31:0] a, input logic [31:0] dat);
        r_en[d] = r; w_en[d] = w; addr_in[d] = a; wdata_in[d] = dat;
    endtask

    task automatic go_idle(input int d);
        r_en[d] = 1'b0; w_en[d] = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Waits (bounded) for ready, then returns just after the DONE edge.
    task automatic wait_done(input int d);
        bit seen = 1'b0;
        for (int c = 0; c < 2 * WC[d] + 4; c++) begin
            @(negedge clk);
            if (ready_o[d]) begin seen = 1'b1; break; end
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("[TB] FAIL w%0d ready timeout: got no ready, expected one", WC[d]);
        end
        next_cycle();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            r_en[d] = 0; w_en[d] = 0; addr_in[d] = 32'd1024; wdata_in[d] = '0;
        end
        @(negedge clk);
        checkOutput("reset freeze", 32'(freeze_o[0]), 32'd0);
        checkOutput("reset we_n", 32'(we_n_o[0]), 32'd1);
        checkOutput("reset oe", 32'(oe_o[0]), 32'd0);
        checkOutput("reset ready", 32'(ready_o[0]), 32'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Store DEADBEEF at 1024, WAIT 4
        applyStimulus(0, 0, 1, 32'd1024, 32'hDEADBEEF);
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            if (c == 0) checkOutput("st freeze c0", 32'(freeze_o[0]), 32'd1);
            if (c == 1) begin
                checkOutput("st lo addr", 32'(saddr_o[0]), 32'd0);
                checkOutput("st lo dq", 32'(dq_o[0]), 32'hBEEF);
                checkOutput("st lo we_n", 32'(we_n_o[0]), 32'd0);
            end
            if (c == 4) checkOutput("st lo last we_n", 32'(we_n_o[0]), 32'd1);
            if (c == 5) begin
                checkOutput("st hi addr", 32'(saddr_o[0]), 32'd1);
                checkOutput("st hi dq", 32'(dq_o[0]), 32'hDEAD);
            end
            if (c == 8) checkOutput("st freeze c8", 32'(freeze_o[0]), 32'd1);
            if (c == 9) begin
                checkOutput("st ready c9", 32'(ready_o[0]), 32'd1);
                checkOutput("st freeze c9", 32'(freeze_o[0]), 32'd0);
            end
        end
        next_cycle();
        go_idle(0);
        next_cycle();

        // Load from 1032, then back-to-back store with both enables high
        mem4[4] = 16'h5678;
        mem4[5] = 16'h1234;
        applyStimulus(0, 1, 0, 32'd1032, 32'h0);
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) checkOutput("ld lo addr", 32'(saddr_o[0]), 32'd4);
            if (c == 2) checkOutput("ld oe", 32'(oe_o[0]), 32'd0);
            if (c == 5) checkOutput("ld hi addr", 32'(saddr_o[0]), 32'd5);
            if (c == 9) begin
                checkOutput("ld ready", 32'(ready_o[0]), 32'd1);
                checkOutput("ld rdata", rdata_o[0], 32'h12345678);
            end
        end
        next_cycle();
        applyStimulus(0, 1, 1, 32'd1040, 32'hCAFEF00D);
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            if (c == 0) checkOutput("b2b freeze c0", 32'(freeze_o[0]), 32'd1);
            if (c == 9) begin
                checkOutput("rw ready", 32'(ready_o[0]), 32'd1);
                checkOutput("rw rdata kept", rdata_o[0], 32'h12345678);
            end
        end
        next_cycle();
        go_idle(0);
        checkOutput("rw mem lo", 32'(sram_read(0, 8)), 32'hF00D);
        checkOutput("rw mem hi", 32'(sram_read(0, 9)), 32'hCAFE);

        // Reset in the middle of a low-half store
        applyStimulus(0, 0, 1, 32'd1024, 32'h11112222);
        repeat (3) @(negedge clk);
        next_cycle();
        rst = 1'b1;
        go_idle(0);
        #1;
        checkOutput("midrst we_n", 32'(we_n_o[0]), 32'd1);
        checkOutput("midrst oe", 32'(oe_o[0]), 32'd0);
        @(negedge clk);
        checkOutput("midrst freeze", 32'(freeze_o[0]), 32'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // WAIT 1: wrapped address store then load
        applyStimulus(1, 0, 1, 32'd1020, 32'h0BADC0DE);
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checkOutput("w1 lo addr", 32'(saddr_o[1]), 32'h3FFFE);
                checkOutput("w1 lo we_n", 32'(we_n_o[1]), 32'd0);
                checkOutput("w1 lo dq", 32'(dq_o[1]), 32'hC0DE);
            end
            if (c == 2) begin
                checkOutput("w1 hi addr", 32'(saddr_o[1]), 32'h3FFFF);
                checkOutput("w1 hi we_n", 32'(we_n_o[1]), 32'd0);
            end
            if (c == 3) checkOutput("w1 ready c3", 32'(ready_o[1]), 32'd1);
        end
        next_cycle();
        go_idle(1);
        next_cycle();
        applyStimulus(1, 1, 0, 32'd1020, 32'h0);
        wait_done(1);
        go_idle(1);
        checkOutput("w1 ld rdata", rdata_o[1], 32'h0BADC0DE);

        // Random traffic on both instances, gaps of 0..2 idle cycles
        for (int n = 0; n < 60; n++) begin
            int d, gap;
            logic [31:0] a;
            bit r, w;
            d = int'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            if (!r && !w) r = 1'b1;
            if ($urandom_range(0, 7) == 0) a = $urandom & 32'hFFFF_FFFC;
            else a = 32'd1024 + ($urandom_range(0, 63) << 2);
            gap = int'($urandom_range(0, 2));
            applyStimulus(d, r, w, a, $urandom);
            wait_done(d);
            go_idle(d);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #2;
            end
        end
        repeat (3) next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
